// File: rtl/frame_buffer_reader.sv
// frame_buffer_reader
//   Sweeps the frame RAM in raster order (addresses 0..PIXELS-1). It issues
//   synchronous reads with 1-cycle latency. Each pixel goes downstream with its
//   x/y position over a valid/ready handshake that the consumer may stall.
// Ports
//   clock, reset          system clock; synchronous active-high reset
//   start, abort          begin a sweep (only from IDLE) / cancel a sweep in progress
//   mem_addr, mem_rd      RAM read address and read enable
//   mem_q                 RAM read data, valid the cycle after a read edge
//   pix_valid, pix_ready  downstream handshake
//   pix_x, pix_y          pixel column / row
//   pix_colour            pixel colour
//   busy                  sweep in progress
//   done                  one-cycle pulse after the last pixel is accepted
module frame_buffer_reader #(
  parameter int unsigned WIDTH    = 320,
  parameter int unsigned HEIGHT   = 180,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned X_W      = 9,
  parameter int unsigned Y_W      = 8,
  parameter int unsigned COLOUR_W = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_rd,
  input  logic [COLOUR_W-1:0] mem_q,
  output logic                pix_valid,
  input  logic                pix_ready,
  output logic [X_W-1:0]      pix_x,
  output logic [Y_W-1:0]      pix_y,
  output logic [COLOUR_W-1:0] pix_colour,
  output logic                busy,
  output logic                done
);

  localparam int unsigned         PIXELS    = WIDTH * HEIGHT;
  localparam logic [ADDR_W-1:0]   LAST_ADDR = ADDR_W'(PIXELS - 1);
  localparam logic [X_W-1:0]      LAST_X    = X_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  state_t state, state_nx;

  // Coordinates of the address about to be issued.
  logic [X_W-1:0]      cx;
  logic [Y_W-1:0]      cy;
  // Read in flight: data appears on mem_q this cycle.
  logic                q_valid;
  logic [X_W-1:0]      q_x;
  logic [Y_W-1:0]      q_y;
  // One-entry skid buffer for a read that lands while the output is stalled.
  logic                sk_valid;
  logic [X_W-1:0]      sk_x;
  logic [Y_W-1:0]      sk_y;
  logic [COLOUR_W-1:0] sk_c;

  logic       take;
  logic [1:0] occ;
  logic       last_take;
  logic       clear;

  assign take = pix_valid & pix_ready;
  // The pixels held after this edge: output plus skid plus the arriving read,
  // minus the one accepted now. A new read is issued only when at most one
  // pixel is held. Its data then always has a slot, even if the consumer stalls.
  // mem_rd depends combinationally on pix_ready, so the pipe runs gap-free.
  assign occ  = {1'b0, pix_valid} + {1'b0, sk_valid} + {1'b0, q_valid} - {1'b0, take};

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= last_take && !abort;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start && !abort) state_nx = READ;
      READ:    if (abort) state_nx = IDLE;
               else if (mem_rd && mem_addr == LAST_ADDR) state_nx = DRAIN;
      DRAIN:   if (abort || last_take) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    mem_rd    = (state == READ) && !abort && (occ <= 2'd1);
    last_take = (state == DRAIN) && take && !sk_valid && !q_valid;
    clear     = (state != IDLE) && (state_nx == IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      mem_addr   <= '0;
      cx         <= '0;
      cy         <= '0;
      q_valid    <= 1'b0;
      q_x        <= '0;
      q_y        <= '0;
      sk_valid   <= 1'b0;
      sk_x       <= '0;
      sk_y       <= '0;
      sk_c       <= '0;
      pix_valid  <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_colour <= '0;
    end else begin
      q_valid <= mem_rd;
      if (mem_rd) begin
        q_x <= cx;
        q_y <= cy;
        if (mem_addr != LAST_ADDR) begin
          mem_addr <= mem_addr + ADDR_W'(1);
          if (cx == LAST_X) begin
            cx <= '0;
            cy <= cy + Y_W'(1);
          end else begin
            cx <= cx + X_W'(1);
          end
        end
      end

      if (!pix_valid || pix_ready) begin
        if (sk_valid) begin
          pix_valid  <= 1'b1;
          pix_x      <= sk_x;
          pix_y      <= sk_y;
          pix_colour <= sk_c;
          sk_valid   <= q_valid;
          if (q_valid) begin
            sk_x <= q_x;
            sk_y <= q_y;
            sk_c <= mem_q;
          end
        end else if (q_valid) begin
          pix_valid  <= 1'b1;
          pix_x      <= q_x;
          pix_y      <= q_y;
          pix_colour <= mem_q;
        end else begin
          pix_valid  <= 1'b0;
        end
      end else if (q_valid) begin
        sk_valid <= 1'b1;
        sk_x     <= q_x;
        sk_y     <= q_y;
        sk_c     <= mem_q;
      end
    end
  end

endmodule
